// File: rtl/mandelbrot_iterator_pkg.sv
// mandelbrot_pkg: shared widths, fixed-point constants and FSM encoding
// for the Mandelbrot pixel iterator.
package mandelbrot_pkg;

    // Complex component word: signed Q6.44
    localparam int Q_LEN    = 50;
    localparam int FRAC_LEN = 44;

    // Iteration limit/count width and opaque pixel tag width
    localparam int ITER_W = 16;
    localparam int TAG_W  = 20;

    // Escape radius squared (4.0) in Q6.44
    localparam logic signed [Q_LEN-1:0] MANDEL_INFINITY = Q_LEN'(4) << FRAC_LEN;

    // The same bound expressed at full squared-product scale (2*FRAC_LEN fraction bits)
    localparam logic signed [2*Q_LEN:0] MAG_LIMIT = (2*Q_LEN+1)'(MANDEL_INFINITY) << FRAC_LEN;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ITER = 2'd1;
    localparam state_t DONE = 2'd2;

    // True when v is a non-zero power of two (1, 2, 4, ...)
    function automatic logic is_pow2(input logic [ITER_W-1:0] v);
        return (v != '0) && ((v & (v - ITER_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/mandelbrot_iterator_if.sv
// mandelbrot_iterator_if: request and result valid/ready channels of the
// Mandelbrot pixel iterator. The slave modport is the iterator itself,
// the master modport is the surrounding producer/consumer.
interface mandelbrot_iterator_if;
    import mandelbrot_pkg::*;

    // Request channel
    logic                     in_valid;
    logic                     in_ready;
    logic signed [Q_LEN-1:0]  c_real;
    logic signed [Q_LEN-1:0]  c_imag;
    logic [ITER_W-1:0]        max_iter;
    logic [TAG_W-1:0]         in_tag;

    // Result channel
    logic                     out_valid;
    logic                     out_ready;
    logic [ITER_W-1:0]        out_count;
    logic                     out_escaped;
    logic [TAG_W-1:0]         out_tag;

    modport slave (
        input  in_valid, c_real, c_imag, max_iter, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_escaped, out_tag
    );

    modport master (
        output in_valid, c_real, c_imag, max_iter, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_escaped, out_tag
    );

endinterface

// File: rtl/mandelbrot_iterator_logic.sv
// mandelbrot_logic: one combinational Mandelbrot step in Q6.44.
// Produces z^2 + C and flags escape when |z|^2 > 4 for the current z.
// The magnitude is compared at full product precision so that |z|^2 == 4
// exactly does not count as escaped; the next-z words simply wrap.
module mandelbrot_logic
    import mandelbrot_pkg::*;
(
    input  logic signed [Q_LEN-1:0] i_z_real,
    input  logic signed [Q_LEN-1:0] i_z_imag,
    input  logic signed [Q_LEN-1:0] i_c_real,
    input  logic signed [Q_LEN-1:0] i_c_imag,
    output logic signed [Q_LEN-1:0] o_next_real,
    output logic signed [Q_LEN-1:0] o_next_imag,
    output logic                    o_finished
);

    logic signed [2*Q_LEN-1:0] w_rr;
    logic signed [2*Q_LEN-1:0] w_ii;
    logic signed [2*Q_LEN-1:0] w_ri;
    logic signed [2*Q_LEN:0]   w_mag;

    // Full-width products of the current z components
    always_comb begin
        w_rr = i_z_real * i_z_real;
        w_ii = i_z_imag * i_z_imag;
        w_ri = i_z_real * i_z_imag;
    end

    // Next z: real = zr^2 - zi^2 + cr, imag = 2*zr*zi + ci, rescaled to Q6.44
    always_comb begin
        o_next_real = Q_LEN'((w_rr - w_ii) >>> FRAC_LEN) + i_c_real;
        o_next_imag = Q_LEN'(w_ri >>> (FRAC_LEN - 1)) + i_c_imag;
    end

    // Escape test on the current z, strictly greater than the radius bound
    always_comb begin
        w_mag      = (2*Q_LEN+1)'(w_rr) + (2*Q_LEN+1)'(w_ii);
        o_finished = (w_mag > MAG_LIMIT);
    end

endmodule

// File: rtl/mandelbrot_iterator.sv
// mandelbrot_iterator: sequential iteration controller for one Mandelbrot
// pixel. Accepts C, an iteration limit and a tag, runs z <- z^2 + C from
// z = 0 at one step per clock, and returns the escape count, an
// inside/outside flag and the tag.
// Optional macro MANDEL_PERIODICITY_EN: stops early when z revisits a value
// saved at a power-of-two iteration; results match the full run.
module mandelbrot_iterator
    import mandelbrot_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mandelbrot_iterator_if.slave  bus
);

    state_t                  r_state;
    logic signed [Q_LEN-1:0] r_c_real;
    logic signed [Q_LEN-1:0] r_c_imag;
    logic signed [Q_LEN-1:0] r_z_real;
    logic signed [Q_LEN-1:0] r_z_imag;
    logic [ITER_W-1:0]       r_iter;
    logic [ITER_W-1:0]       r_max_iter;
    logic [TAG_W-1:0]        r_tag;
    logic [ITER_W-1:0]       r_count;
    logic                    r_escaped;

    logic signed [Q_LEN-1:0] w_next_real;
    logic signed [Q_LEN-1:0] w_next_imag;
    logic                    w_finished;
    logic                    w_at_limit;

`ifdef MANDEL_PERIODICITY_EN
    logic signed [Q_LEN-1:0] r_saved_real;
    logic signed [Q_LEN-1:0] r_saved_imag;
    logic                    r_saved_valid;
    logic                    w_cycle_hit;
`endif

    // Single combinational step fed from the z and C registers
    mandelbrot_logic u_step (
        .i_z_real    (r_z_real),
        .i_z_imag    (r_z_imag),
        .i_c_real    (r_c_real),
        .i_c_imag    (r_c_imag),
        .o_next_real (w_next_real),
        .o_next_imag (w_next_imag),
        .o_finished  (w_finished)
    );

    // Termination conditions evaluated on the current z
    always_comb begin
        w_at_limit = (r_iter == r_max_iter);
`ifdef MANDEL_PERIODICITY_EN
        w_cycle_hit = r_saved_valid
                   && (r_z_real == r_saved_real)
                   && (r_z_imag == r_saved_imag);
`endif
    end

    // Handshake flags and results are decoded from registers only
    always_comb begin
        bus.in_ready    = (r_state == IDLE);
        bus.out_valid   = (r_state == DONE);
        bus.out_count   = r_count;
        bus.out_escaped = r_escaped;
        bus.out_tag     = r_tag;
    end

    // Control FSM plus datapath registers; reset drops any in-flight pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_c_real   <= '0;
            r_c_imag   <= '0;
            r_z_real   <= '0;
            r_z_imag   <= '0;
            r_iter     <= '0;
            r_max_iter <= '0;
            r_tag      <= '0;
            r_count    <= '0;
            r_escaped  <= 1'b0;
`ifdef MANDEL_PERIODICITY_EN
            r_saved_real  <= '0;
            r_saved_imag  <= '0;
            r_saved_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_c_real   <= bus.c_real;
                        r_c_imag   <= bus.c_imag;
                        r_max_iter <= bus.max_iter;
                        r_tag      <= bus.in_tag;
                        r_z_real   <= '0;
                        r_z_imag   <= '0;
                        r_iter     <= '0;
`ifdef MANDEL_PERIODICITY_EN
                        r_saved_real  <= '0;
                        r_saved_imag  <= '0;
                        r_saved_valid <= 1'b0;
`endif
                        r_state    <= ITER;
                    end
                end

                ITER: begin
                    if (w_finished) begin
                        r_count   <= r_iter;
                        r_escaped <= 1'b1;
                        r_state   <= DONE;
                    end else if (w_at_limit) begin
                        r_count   <= r_max_iter;
                        r_escaped <= 1'b0;
                        r_state   <= DONE;
`ifdef MANDEL_PERIODICITY_EN
                    end else if (w_cycle_hit) begin
                        r_count   <= r_max_iter;
                        r_escaped <= 1'b0;
                        r_state   <= DONE;
`endif
                    end else begin
                        r_z_real <= w_next_real;
                        r_z_imag <= w_next_imag;
                        r_iter   <= r_iter + ITER_W'(1);
`ifdef MANDEL_PERIODICITY_EN
                        if (is_pow2(r_iter)) begin
                            r_saved_real  <= r_z_real;
                            r_saved_imag  <= r_z_imag;
                            r_saved_valid <= 1'b1;
                        end
`endif
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// tb_mandelbrot_iterator: directed self-checking bench for the Mandelbrot
// pixel iterator with hand-computed counts, flags, tags and latencies.
module tb_mandelbrot_iterator;
    import mandelbrot_pkg::*;

    localparam logic signed [Q_LEN-1:0] ONE   = Q_LEN'(1) << FRAC_LEN;
    localparam logic signed [Q_LEN-1:0] TWO   = Q_LEN'(2) << FRAC_LEN;
    localparam logic signed [Q_LEN-1:0] THREE = Q_LEN'(3) << FRAC_LEN;
    localparam logic signed [Q_LEN-1:0] ZERO  = '0;

`ifdef MANDEL_PERIODICITY_EN
    localparam int CYCLE_LATENCY = 5;
`else
    localparam int CYCLE_LATENCY = 1001;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mandelbrot_iterator_if bus();

    mandelbrot_iterator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic signed [Q_LEN-1:0] cr, input logic signed [Q_LEN-1:0] ci,
                                 input logic [ITER_W-1:0] mi, input logic [TAG_W-1:0] tag);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            nextCycle();
            guard++;
        end
        checkOutput("in_ready_idle", 64'(bus.in_ready), 64'(1));
        bus.c_real   = cr;
        bus.c_imag   = ci;
        bus.max_iter = mi;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        nextCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic popResult(input string name, input logic [ITER_W-1:0] expCount, input logic expEsc,
                             input logic [TAG_W-1:0] expTag, input int expLat, input int holdCycles);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 1100) begin
            nextCycle();
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
        for (int h = 0; h <= holdCycles; h++) begin
            checkOutput({name, "_out_valid"}, 64'(bus.out_valid), 64'(1));
            checkOutput({name, "_count"}, 64'(bus.out_count), 64'(expCount));
            checkOutput({name, "_escaped"}, 64'(bus.out_escaped), 64'(expEsc));
            checkOutput({name, "_tag"}, 64'(bus.out_tag), 64'(expTag));
            checkOutput({name, "_in_ready_done"}, 64'(bus.in_ready), 64'(0));
            if (h < holdCycles) nextCycle();
        end
        bus.out_ready = 1'b1;
        nextCycle();
        bus.out_ready = 1'b0;
        checkOutput({name, "_out_valid_after"}, 64'(bus.out_valid), 64'(0));
        checkOutput({name, "_in_ready_after"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_real    = '0;
        bus.c_imag    = '0;
        bus.max_iter  = '0;
        bus.in_tag    = '0;
        nextCycle();
        nextCycle();
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("reset_count", 64'(bus.out_count), 64'(0));
        checkOutput("reset_escaped", 64'(bus.out_escaped), 64'(0));
        checkOutput("reset_tag", 64'(bus.out_tag), 64'(0));
        rst = 1'b0;
        nextCycle();

        // C = 0 never escapes: runs to the limit in 17 ITER cycles
        applyStimulus(ZERO, ZERO, 16'd16, 20'h00011);
        popResult("c0", 16'd16, 1'b0, 20'h00011, 17, 0);

        // C = 2: z = 0, 2 (|z|^2 = 4 stays), 6 escapes at iter 2
        applyStimulus(TWO, ZERO, 16'd100, 20'h00022);
        popResult("c2", 16'd2, 1'b1, 20'h00022, 3, 0);

        // C = 2 with limit 1: limit hit while |z|^2 = 4 exactly
        applyStimulus(TWO, ZERO, 16'd1, 20'h00023);
        popResult("c2lim1", 16'd1, 1'b0, 20'h00023, 2, 0);

        // C = 1+1i: z1 = 1+i (|z|^2=2), z2 = 1+3i (10) escapes
        applyStimulus(ONE, ONE, 16'd10, 20'h00024);
        popResult("c1i1", 16'd2, 1'b1, 20'h00024, 3, 0);

        // C = 2i: z1 = 2i (4 stays), z2 = -4+2i escapes
        applyStimulus(ZERO, TWO, 16'd10, 20'h00025);
        popResult("ci2", 16'd2, 1'b1, 20'h00025, 3, 0);

        // C = -2: z sits at 2, runs to limit; consumer stalls 5 cycles
        applyStimulus(-TWO, ZERO, 16'd50, 20'h00033);
        popResult("cm2", 16'd50, 1'b0, 20'h00033, 51, 5);

        // C = 3: escapes on the first non-trivial z
        applyStimulus(THREE, ZERO, 16'd5, 20'h00044);
        popResult("c3", 16'd1, 1'b0 | 1'b1, 20'h00044, 2, 0);

        // Limit 0: one ITER cycle, count 0, even for an escaping C
        applyStimulus(THREE, ONE, 16'd0, 20'h000A1);
        popResult("lim0a", 16'd0, 1'b0, 20'h000A1, 1, 0);
        applyStimulus(-ONE, ZERO, 16'd0, 20'h000A2);
        popResult("lim0b", 16'd0, 1'b0, 20'h000A2, 1, 0);
        applyStimulus(ZERO, -TWO, 16'd0, 20'hFFFA3);
        popResult("lim0c", 16'd0, 1'b0, 20'hFFFA3, 1, 0);

        // Reset during the third ITER cycle discards the pixel
        applyStimulus(ZERO, ZERO, 16'd16, 20'h0BEEF);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("midrst_count", 64'(bus.out_count), 64'(0));
        checkOutput("midrst_escaped", 64'(bus.out_escaped), 64'(0));
        checkOutput("midrst_tag", 64'(bus.out_tag), 64'(0));
        nextCycle();
        rst = 1'b0;
        nextCycle();
        applyStimulus(TWO, ZERO, 16'd100, 20'h00055);
        popResult("post_rst", 16'd2, 1'b1, 20'h00055, 3, 0);

        // C = -1: z alternates 0, -1; periodicity check shortens latency
        applyStimulus(-ONE, ZERO, 16'd1000, 20'h00066);
        popResult("cm1", 16'd1000, 1'b0, 20'h00066, CYCLE_LATENCY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
